alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
Byte-stream front end that drives the combinational ALU on behalf of the command line interface. It assembles a 9-byte command frame (opcode, OperA, OperB), drives stable operands and the ALU code, and waits a fixed settle time. It then captures Result and the four flags and returns them as a 5-byte response frame. It sits between the CLI byte channel (UART side) and the ALU's OperA/OperB/ALU_Code inputs and Result/Zero/Negative/Carry/Overflow outputs.

Parameters:
SETTLE, 2, cycles the ALU inputs are held before Result/flags are sampled; legal range 1..15.
TIMEOUT, 1000, idle cycles allowed between bytes of a partial frame before it is aborted; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_data  in  8  command byte
in_valid  in  1  in_data valid
in_ready  out  1  block accepts a byte this cycle
out_data  out  8  response byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
alu_oper_a  out  32  to ALU OperA
alu_oper_b  out  32  to ALU OperB
alu_code  out  2  to ALU ALU_Code
alu_result  in  32  from ALU Result
alu_zero  in  1  from ALU Zero
alu_negative  in  1  from ALU Negative
alu_carry  in  1  from ALU Carry
alu_overflow  in  1  from ALU Overflow
busy  out  1  high in any state other than IDLE
frame_abort  out  1  one-cycle pulse when a partial frame times out

Behaviour:
- Reset (async on rst_n low): state IDLE. alu_oper_a, alu_oper_b, alu_code, out_data, out_valid, busy, frame_abort and the capture registers are all 0. in_ready is 1 from the first cycle after release.
- A byte is accepted on a rising edge with in_valid && in_ready. An edge with out_valid && out_ready transfers a response byte.
- Frame format: byte0 is the opcode; bits[1:0] are the ALU code and bits[7:2] must be 0, otherwise the frame is flagged err. Bytes 1-4 are OperA, MSB first. Bytes 5-8 are OperB, MSB first.
- States:
  - IDLE: in_ready=1. Accepting byte0 -> RX.
  - RX: in_ready=1, with a byte counter from 1 to 8. Accepting byte 8 -> EXEC.
  - EXEC: in_ready=0. The state lasts exactly SETTLE cycles, then -> TX.
  - TX: in_ready=0. Accepting the 5th byte -> IDLE.
- alu_oper_a, alu_oper_b and alu_code load on the edge that accepts byte 8, so they are valid in the first EXEC cycle. They then hold until the next frame's byte 8 is accepted, including through TX and IDLE. They never change mid-frame.
- Capture: on the final EXEC edge, alu_result and the four flags are registered. out_valid rises in the next cycle. Latency from the byte-8 accept edge to out_valid high is SETTLE+1 cycles.
- Response bytes, in order:
  - Status {err, 3'b000, zero, negative, carry, overflow}.
  - Result[31:24], Result[23:16], Result[15:8], Result[7:0].
- err frames: all 9 bytes are still consumed. The ALU registers are not updated and EXEC is still traversed. The response is status 0x80 followed by four 0x00 bytes.
- TX stall: out_data and out_valid hold stable while out_ready=0. out_valid stays high continuously across the 5 bytes whenever out_ready=1. out_valid falls on the edge that accepts byte 5.
- Back-to-back frames: in_ready rises the cycle after the response's byte 5 is accepted. No byte is accepted during EXEC or TX, so input is back-pressured.
- Timeout (TIMEOUT>0): the counter runs only in RX and clears on every accepted byte. After TIMEOUT consecutive cycles with no byte accepted, the block returns to IDLE and frame_abort pulses for one cycle. No response is sent and the ALU registers are unchanged.
- A byte presented in the same cycle the timeout expires is not accepted; it waits and is then taken as byte0 in IDLE.
- Reset mid-frame or mid-response: the partial frame and the response are discarded, out_valid drops immediately, and all registers return to their reset values.

Test Plan:
- Bench ALU stub = OperA+OperB, with flags taken from the 33-bit sum. Frame 00 00 00 00 FF 00 00 00 FF, out_ready=1 -> out_valid 3 cycles after the byte-8 accept. Response 00 00 00 01 FE; alu_oper_a=alu_oper_b=0xFF and alu_code=0 held.
- Same stub, frame 00 FF FF FF FF 00 00 00 01 -> response 0x0A 00 00 00 00 (Z=1, C=1).
- Opcode 0x05 followed by 8 bytes -> response 80 00 00 00 00; ALU outputs keep the previous frame's values.
- out_ready low for 7 cycles during byte 2 -> out_data=0x00 stable throughout; no byte lost or duplicated; the total response is still exactly 5 bytes.
- TIMEOUT=20: send 3 bytes then idle 20 cycles -> frame_abort pulses once and busy=0. A subsequent full frame is processed normally.
- Assert rst_n low during TX byte 3 -> out_valid=0, busy=0 and ALU outputs=0 asynchronously. in_ready=1 after release.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Byte-stream front end for the combinational ALU: assembles a 9-byte command,
// drives the ALU, waits SETTLE cycles, then returns a 5-byte status/result frame.
module alu_cmd_issuer #(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_oper_a,
    output logic [31:0] alu_oper_b,
    output logic [1:0]  alu_code,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    output logic        busy,
    output logic        frame_abort
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RX, EXEC, TX} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic [55:0] r_sh;
    logic [1:0]  r_code_rx;
    logic        r_err;
    logic [31:0] r_oper_a, r_oper_b;
    logic [1:0]  r_code;
    logic [31:0] r_res;
    logic [3:0]  r_flags;
    logic        r_out_valid;
    logic        r_abort;
    logic [TW-1:0] r_tmo;

    logic       w_in_ready, w_in_acc, w_out_acc, w_tmo, w_settled;
    logic [7:0] w_byte;

    assign w_tmo     = (TIMEOUT > 0) && (r_state == RX) && (r_tmo == TW'(TIMEOUT - 1));
    assign w_in_acc  = in_valid && w_in_ready;
    assign w_out_acc = r_out_valid && out_ready;
    assign w_settled = (r_state == EXEC) && (r_cnt == 4'(SETTLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next = RX;
            end
            RX: begin
                // the expiring cycle refuses input so the byte lands as a fresh byte0
                w_in_ready = !w_tmo;
                if (w_tmo)                         w_next = IDLE;
                else if (in_valid && r_cnt == 4'd8) w_next = EXEC;
            end
            EXEC: if (w_settled) w_next = TX;
            TX:   if (w_out_acc && r_cnt == 4'd4) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_sh        <= '0;
            r_code_rx   <= '0;
            r_err       <= 1'b0;
            r_oper_a    <= '0;
            r_oper_b    <= '0;
            r_code      <= '0;
            r_res       <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
            r_abort     <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_abort <= w_tmo;
            case (r_state)
                IDLE: if (w_in_acc) begin
                    r_err     <= |in_data[7:2];
                    r_code_rx <= in_data[1:0];
                    r_cnt     <= 4'd1;
                    r_tmo     <= '0;
                end
                RX: begin
                    if (w_tmo) begin
                        r_cnt <= '0;
                    end else if (w_in_acc) begin
                        r_sh  <= {r_sh[47:0], in_data};
                        r_tmo <= '0;
                        if (r_cnt == 4'd8) begin
                            r_cnt <= '0;
                            if (!r_err) begin
                                r_oper_a <= r_sh[55:24];
                                r_oper_b <= {r_sh[23:0], in_data};
                                r_code   <= r_code_rx;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                EXEC: begin
                    if (w_settled) begin
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        // err frames answer with zeros, whatever the ALU shows
                        r_res       <= r_err ? 32'h0 : alu_result;
                        r_flags     <= r_err ? 4'h0 :
                                       {alu_zero, alu_negative, alu_carry, alu_overflow};
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                TX: if (w_out_acc) begin
                    if (r_cnt == 4'd4) begin
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_cnt)
            4'd0: w_byte = {r_err, 3'b000, r_flags};
            4'd1: w_byte = r_res[31:24];
            4'd2: w_byte = r_res[23:16];
            4'd3: w_byte = r_res[15:8];
            4'd4: w_byte = r_res[7:0];
            default: w_byte = 8'h00;
        endcase
    end

    assign in_ready    = w_in_ready;
    assign out_data    = r_out_valid ? w_byte : 8'h00;
    assign out_valid   = r_out_valid;
    assign alu_oper_a  = r_oper_a;
    assign alu_oper_b  = r_oper_b;
    assign alu_code    = r_code;
    assign busy        = (r_state != IDLE);
    assign frame_abort = r_abort;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: hand vectors, timeout/reset sequences and random
// frames checked against a frame-level model driving an adder ALU stub.
module tb_alu_cmd_issuer;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_oper_a, alu_oper_b, alu_result;
    logic [1:0]  alu_code;
    logic        alu_zero, alu_negative, alu_carry, alu_overflow;
    logic        busy, frame_abort;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_oper_a(alu_oper_a), .alu_oper_b(alu_oper_b), .alu_code(alu_code),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .busy(busy), .frame_abort(frame_abort)
    );

    // ALU stub: 32-bit adder
    logic [32:0] stub_sum;
    assign stub_sum     = {1'b0, alu_oper_a} + {1'b0, alu_oper_b};
    assign alu_result   = stub_sum[31:0];
    assign alu_zero     = (stub_sum[31:0] == 32'h0);
    assign alu_negative = stub_sum[31];
    assign alu_carry    = stub_sum[32];
    assign alu_overflow = (alu_oper_a[31] == alu_oper_b[31]) && (stub_sum[31] != alu_oper_a[31]);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // frame-level model: what the ALU should hold and what comes back
    logic [31:0] m_a = 0, m_b = 0;
    logic [1:0]  m_code = 0;

    task automatic model_frame(input logic [71:0] f, output logic [39:0] resp);
        logic [7:0]  op;
        logic [31:0] a, b, r;
        logic [32:0] s;
        op = f[71:64];
        if (op[7:2] != 6'd0) begin
            resp = {8'h80, 32'h0};
        end else begin
            a = f[63:32];
            b = f[31:0];
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0];
            resp = {4'b0000, (r == 0), r[31], s[32], (a[31] == b[31]) && (r[31] != a[31]), r};
            m_a = a; m_b = b; m_code = op[1:0];
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) chk("in_ready_wait", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic get_resp(output logic [39:0] r, input int sb, input int sl);
        int t;
        logic [7:0] d;
        r = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                t = 0;
                while (!out_valid && t < 50) begin
                    @(posedge clk); #1; t++;
                end
                chk("ov_rise", out_valid, 1);
            end else begin
                chk("ov_cont", out_valid, 1);
            end
            if (k == sb && sl > 0) begin
                out_ready = 1'b0;
                d = out_data;
                repeat (sl) begin
                    @(posedge clk); #1;
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, d);
                end
                out_ready = 1'b1;
            end
            r[39-8*k -: 8] = out_data;
            @(posedge clk); #1;
        end
        chk("ov_fall", out_valid, 0);
        out_ready = 1'b0;
    endtask

    task automatic run_frame(input logic [71:0] f, input logic [39:0] er,
                             input logic [31:0] ea, input logic [31:0] eb, input logic [1:0] ec,
                             input int sb, input int sl, input int gap);
        int n;
        logic [39:0] r;
        for (int i = 0; i < 9; i++) begin
            send_byte(f[71-8*i -: 8]);
            if (i < 8 && gap > 0)
                repeat ($urandom_range(gap, 0)) begin @(posedge clk); #1; end
        end
        chk("busy_exec", busy, 1);
        chk("in_ready_exec", in_ready, 0);
        chk("oper_a_exec", alu_oper_a, ea);
        chk("oper_b_exec", alu_oper_b, eb);
        chk("code_exec", alu_code, ec);
        n = 1;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, SETTLE + 1);
        get_resp(r, sb, sl);
        chk("resp", r, er);
        chk("oper_a_hold", alu_oper_a, ea);
        chk("oper_b_hold", alu_oper_b, eb);
        chk("code_hold", alu_code, ec);
        chk("in_ready_idle", in_ready, 1);
        chk("busy_idle", busy, 0);
    endtask

    typedef struct {
        logic [71:0] frame;
        logic [39:0] resp;
        logic [31:0] a, b;
        logic [1:0]  code;
        int          sb, sl;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [31:0] pick();
        case ($urandom_range(4, 0))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [39:0] mr;
        logic [71:0] f;
        logic [7:0]  op;
        int cnt, first, t;

        tbl[0] = '{72'h00_000000FF_000000FF, 40'h00_000001FE, 32'h0000_00FF, 32'h0000_00FF, 2'd0, 1, 7};
        tbl[1] = '{72'h00_FFFFFFFF_00000001, 40'h0A_00000000, 32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 0, 0};
        tbl[2] = '{72'h05_12345678_9ABCDEF0, 40'h80_00000000, 32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 4, 2};
        tbl[3] = '{72'h03_7FFFFFFF_00000001, 40'h05_80000000, 32'h7FFF_FFFF, 32'h0000_0001, 2'd3, 0, 3};
        tbl[4] = '{72'h02_80000000_80000000, 40'h0B_00000000, 32'h8000_0000, 32'h8000_0000, 2'd2, 2, 1};
        tbl[5] = '{72'hFC_00000001_00000002, 40'h80_00000000, 32'h8000_0000, 32'h8000_0000, 2'd2, 0, 0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_abort", frame_abort, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_oper_a", alu_oper_a, 0);
        chk("rst_oper_b", alu_oper_b, 0);
        chk("rst_code", alu_code, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].frame, tbl[i].resp, tbl[i].a, tbl[i].b, tbl[i].code,
                      tbl[i].sb, tbl[i].sl, 0);
            model_frame(tbl[i].frame, mr);
        end

        // timeout: 3 bytes then silence
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        cnt = 0; first = 0;
        for (int n = 1; n <= 30; n++) begin
            if (frame_abort) begin
                cnt++;
                if (first == 0) first = n;
            end
            if (n == 21) chk("tmo_busy", busy, 0);
            @(posedge clk); #1;
        end
        chk("abort_count", cnt, 1);
        chk("abort_cycle", first, 21);
        chk("tmo_oper_a", alu_oper_a, m_a);
        chk("tmo_oper_b", alu_oper_b, m_b);
        run_frame(tbl[0].frame, tbl[0].resp, tbl[0].a, tbl[0].b, tbl[0].code, 0, 0, 0);
        model_frame(tbl[0].frame, mr);

        // byte arriving in the expiring cycle becomes byte0 of the next frame
        send_byte(8'h00); send_byte(8'h33); send_byte(8'h44);
        repeat (19) begin @(posedge clk); #1; end
        in_data = tbl[1].frame[71:64];
        in_valid = 1'b1;
        chk("tmo_edge_rdy", in_ready, 0);
        @(posedge clk); #1;
        chk("tmo_edge_abort", frame_abort, 1);
        chk("tmo_edge_busy", busy, 0);
        run_frame(tbl[1].frame, tbl[1].resp, tbl[1].a, tbl[1].b, tbl[1].code, 3, 2, 0);
        model_frame(tbl[1].frame, mr);

        // random frames against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3, 0) == 0) op = {6'($urandom_range(63, 1)), 2'($urandom)};
            else                           op = {6'b0, 2'($urandom)};
            f = {op, pick(), pick()};
            model_frame(f, mr);
            run_frame(f, mr, m_a, m_b, m_code, $urandom_range(4, 0), $urandom_range(3, 0), 3);
        end

        // reset during response byte 3
        for (int i = 0; i < 9; i++) send_byte(tbl[3].frame[71-8*i -: 8]);
        t = 0;
        while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_data", out_data, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_oper_a", alu_oper_a, 0);
        chk("mid_rst_oper_b", alu_oper_b, 0);
        chk("mid_rst_code", alu_code, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_valid", out_valid, 0);
        m_a = 0; m_b = 0; m_code = 0;
        run_frame(tbl[2].frame, tbl[2].resp, 32'h0, 32'h0, 2'd0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
